regfile_write_arbiter: RTL and testbench

//  Shares the single write port (we/rd/in) of the 32x32 register file among
//  NUM_REQ writeback sources (ALU, load unit, mul/div, ...) with round-robin

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback requester index map.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [2:0] {
    REQ_ALU    = 3'd0,
    REQ_LOAD   = 3'd1,
    REQ_MULDIV = 3'd2
  } req_idx_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from r_ptr upward with wrap.
// r_ptr moves to the slot after the winner and holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         Clk,
  input  logic         resetControl,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_next_ptr;
  logic             w_any;

  // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
  always_comb begin
    int j;
    grant      = '0;
    w_any      = 1'b0;
    w_next_ptr = r_ptr;
    j          = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (en && !w_any && req[j]) begin
        grant[j]   = 1'b1;
        w_any      = 1'b1;
        w_next_ptr = (j == N - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (resetControl) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_next_ptr;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources.
// Optional RWA_DROP_R0_EN: writes to r0 are accepted and dropped outside arbitration.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                      Clk,
  input  logic                      resetControl,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        wb_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] wb_rd,
  input  logic [NUM_REQ*DATA_W-1:0] wb_data,
  output logic [NUM_REQ-1:0]        wb_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_in,
  input  logic [ADDR_W-1:0]         rs,
  input  logic [ADDR_W-1:0]         rt,
  output logic                      pend_rs,
  output logic                      pend_rt
);
  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_drop;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_arb_en;
  logic [ADDR_W-1:0]  w_sel_rd;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_hit_rs;
  logic               w_hit_rt;

  logic               r_we;
  logic [ADDR_W-1:0]  r_rd;
  logic [DATA_W-1:0]  r_in;

  assign w_arb_en = !stall && !resetControl;

`ifdef RWA_DROP_R0_EN
  logic [NUM_REQ-1:0] w_is_r0;

  always_comb begin
    w_is_r0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_is_r0[i] = (wb_rd[i*ADDR_W +: ADDR_W] == '0);
    end
  end

  // r0 writes bypass arbitration and stall; reset still blocks acceptance.
  assign w_arb_req = wb_valid & ~w_is_r0;
  assign w_drop    = resetControl ? '0 : (wb_valid & w_is_r0);
`else
  assign w_arb_req = wb_valid;
  assign w_drop    = '0;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .Clk          (Clk),
    .resetControl (resetControl),
    .req          (w_arb_req),
    .en           (w_arb_en),
    .grant        (w_grant)
  );

  assign wb_ready = w_grant | w_drop;

  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_rd   = w_sel_rd   | wb_rd[i*ADDR_W +: ADDR_W];
        w_sel_data = w_sel_data | wb_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: address/data are reset too because their post-reset value is observable on rf_rd/rf_in.
  always_ff @(posedge Clk) begin
    if (resetControl) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_in <= '0;
    end else begin
      r_we <= |w_grant;
      if (|w_grant) begin
        r_rd <= w_sel_rd;
        r_in <= w_sel_data;
      end
    end
  end

  assign rf_we = r_we;
  assign rf_rd = r_rd;
  assign rf_in = r_in;

  // A write is in flight if any source is still requesting it or it sits in the output register.
  always_comb begin
    w_hit_rs = r_we && (r_rd == rs);
    w_hit_rt = r_we && (r_rd == rt);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wb_valid[i] && (wb_rd[i*ADDR_W +: ADDR_W] == rs)) w_hit_rs = 1'b1;
      if (wb_valid[i] && (wb_rd[i*ADDR_W +: ADDR_W] == rt)) w_hit_rt = 1'b1;
    end
  end

  assign pend_rs = (rs != '0) && w_hit_rs;
  assign pend_rt = (rt != '0) && w_hit_rt;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// request-queue model of the arbiter. Honours RWA_DROP_R0_EN when defined.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NUM_REQ = 3;

  logic                      Clk;
  logic                      resetControl;
  logic                      stall;
  logic [NUM_REQ-1:0]        wb_valid;
  logic [NUM_REQ*ADDR_W-1:0] wb_rd;
  logic [NUM_REQ*DATA_W-1:0] wb_data;
  logic [NUM_REQ-1:0]        wb_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_rd;
  logic [DATA_W-1:0]         rf_in;
  logic [ADDR_W-1:0]         rs;
  logic [ADDR_W-1:0]         rt;
  logic                      pend_rs;
  logic                      pend_rt;

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk          (Clk),
    .resetControl (resetControl),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_in        (rf_in),
    .rs           (rs),
    .rt           (rt),
    .pend_rs      (pend_rs),
    .pend_rt      (pend_rt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pending request of each source, as the sources see it.
  logic              req_v    [NUM_REQ];
  logic [ADDR_W-1:0] req_rd   [NUM_REQ];
  logic [DATA_W-1:0] req_data [NUM_REQ];

  always_comb begin
    wb_valid = '0;
    wb_rd    = '0;
    wb_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wb_valid[i]                  = req_v[i];
      wb_rd[i*ADDR_W +: ADDR_W]    = req_rd[i];
      wb_data[i*DATA_W +: DATA_W]  = req_data[i];
    end
  end

  // Reference state: next search start and the write the register file should see.
  int                m_ptr;
  logic              m_we;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_in;
  bit                m_known;
  bit                refill;
  int                n_checks;
  int                n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit dropped(input int i);
`ifdef RWA_DROP_R0_EN
    return req_rd[i] == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic in_flight(input logic [ADDR_W-1:0] x);
    logic hit;
    hit = m_we && (m_rd == x);
    for (int i = 0; i < NUM_REQ; i++)
      if (req_v[i] && req_rd[i] == x) hit = 1'b1;
    return (x != '0) && hit;
  endfunction

  task automatic new_req(input int i, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    req_v[i]    = 1'b1;
    req_rd[i]   = rd;
    req_data[i] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) req_v[i] = 1'b0;
  endtask

  // One clock: check outputs against the model, advance the model past the edge.
  task automatic cycle();
    int                 g;
    logic [NUM_REQ-1:0] er;
    #1;
    g  = -1;
    er = '0;
    if (!resetControl && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
        if (g < 0 && req_v[j] && !dropped(j)) g = j;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    if (!resetControl)
      for (int i = 0; i < NUM_REQ; i++)
        if (req_v[i] && dropped(i)) er[i] = 1'b1;
    check("wb_ready", 32'(wb_ready), 32'(er));
    if (m_known) begin
      check("rf_we", 32'(rf_we), 32'(m_we));
      check("rf_rd", 32'(rf_rd), 32'(m_rd));
      check("rf_in", rf_in, m_in);
      check("pend_rs", 32'(pend_rs), 32'(in_flight(rs)));
      check("pend_rt", 32'(pend_rt), 32'(in_flight(rt)));
    end
    @(posedge Clk);
    #1;
    if (resetControl) begin
      m_ptr   = 0;
      m_we    = 1'b0;
      m_rd    = '0;
      m_in    = '0;
      m_known = 1'b1;
    end else begin
      m_we = (g >= 0);
      if (g >= 0) begin
        m_rd  = req_rd[g];
        m_in  = req_data[g];
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (er[i]) begin
        req_v[i] = 1'b0;
        if (refill) new_req(i, ADDR_W'($urandom_range(1, 31)), $urandom);
      end
    end
    @(negedge Clk);
  endtask

  task automatic reset_pulse();
    clear_reqs();
    resetControl = 1'b1;
    cycle();
    resetControl = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_ptr    = 0;
    m_we     = 1'b0;
    m_rd     = '0;
    m_in     = '0;
    m_known  = 1'b0;
    refill   = 1'b0;
    stall    = 1'b0;
    rs       = '0;
    rt       = '0;
    for (int i = 0; i < NUM_REQ; i++) new_req(i, ADDR_W'(i + 1), 32'h100 + 32'(i));

    // Reset held 3 cycles with all sources requesting.
    resetControl = 1'b1;
    repeat (3) cycle();
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_rd", 32'(rf_rd), 32'd0);
    check("rst_rf_in", rf_in, 32'd0);
    resetControl = 1'b0;
    #1 check("first_grant", 32'(wb_ready), 32'b001);
    cycle();

    // Round robin with sources re-presenting after each acceptance.
    refill = 1'b1;
    repeat (6) cycle();
    refill = 1'b0;
    repeat (4) cycle();

    // Latency of a single write.
    clear_reqs();
    new_req(int'(REQ_LOAD), 5'd5, 32'hDEADBEEF);
    #1 check("lat_ready", 32'(wb_ready), 32'b010);
    cycle();
    #1;
    check("lat_we", 32'(rf_we), 32'd1);
    check("lat_rd", 32'(rf_rd), 32'd5);
    check("lat_in", rf_in, 32'hDEADBEEF);
    cycle();
    #1 check("lat_we_off", 32'(rf_we), 32'd0);

    // Stall blocks the grant, which then lands on the first free cycle.
    new_req(int'(REQ_LOAD), 5'd9, 32'h1234);
    stall = 1'b1;
    repeat (2) begin
      #1;
      check("stall_ready", 32'(wb_ready), 32'd0);
      check("stall_we", 32'(rf_we), 32'd0);
      cycle();
    end
    stall = 1'b0;
    #1 check("unstall_ready", 32'(wb_ready), 32'b010);
    cycle();
    cycle();

    // Two sources to the same register, hazard on rs only.
    reset_pulse();
    new_req(int'(REQ_ALU), 5'd7, 32'd1);
    new_req(int'(REQ_MULDIV), 5'd7, 32'd2);
    rs = 5'd7;
    rt = 5'd0;
    #1;
    check("haz_rs", 32'(pend_rs), 32'd1);
    check("haz_rt", 32'(pend_rt), 32'd0);
    cycle();
    #1 check("same_rd_1st", rf_in, 32'd1);
    cycle();
    #1;
    check("same_rd_2nd", rf_in, 32'd2);
    check("haz_rs_reg", 32'(pend_rs), 32'd1);
    cycle();
    #1;
    check("haz_rs_clear", 32'(pend_rs), 32'd0);
    check("same_rd_we_off", 32'(rf_we), 32'd0);

    // Write to r0.
    reset_pulse();
    new_req(int'(REQ_LOAD), 5'd0, 32'd9);
`ifdef RWA_DROP_R0_EN
    stall = 1'b1;
    #1 check("r0_ready", 32'(wb_ready), 32'b010);
    cycle();
    stall = 1'b0;
    #1 check("r0_no_we", 32'(rf_we), 32'd0);
    new_req(int'(REQ_LOAD), 5'd3, 32'h33);
    new_req(int'(REQ_MULDIV), 5'd4, 32'h44);
    #1 check("r0_ptr_hold", 32'(wb_ready), 32'b010);
    cycle();
    cycle();
`else
    #1 check("r0_ready", 32'(wb_ready), 32'b010);
    cycle();
    #1;
    check("r0_we", 32'(rf_we), 32'd1);
    check("r0_rd", 32'(rf_rd), 32'd0);
    check("r0_in", rf_in, 32'd9);
    cycle();
`endif

    // Random traffic with stalls, occasional resets and r0 writes.
    clear_reqs();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_v[i] && $urandom_range(0, 1) == 1)
          new_req(i, ADDR_W'($urandom_range(0, 7)), $urandom);
      stall        = ($urandom_range(0, 4) == 0);
      resetControl = ($urandom_range(0, 59) == 0);
      rs           = ADDR_W'($urandom_range(0, 7));
      rt           = ADDR_W'($urandom_range(0, 7));
      cycle();
    end
    resetControl = 1'b0;
    stall        = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
